// File: rtl/sound_sequencer.sv
// Session controller for the sound recorder: sequences record/playback, arms the recorder,
// paces playback reads at the sample rate and shares the recorder read port with a host dump port.
module sound_sequencer #(
  parameter int SAMPLE_INTERVAL_CLK = 3000,
  parameter int MEMORY_SIZE         = 441000,
  parameter int ADDR_W              = 19,
  parameter int DATA_W              = 10
) (
  input  logic              clk,
  input  logic              reset_n_clk,
  input  logic              rec_req,
  input  logic              play_req,
  input  logic              stop_req,
  input  logic              dump_req,
  input  logic [ADDR_W-1:0] dump_addr,
  input  logic [ADDR_W-1:0] write_pointer,
  input  logic [DATA_W-1:0] read_data,
  output logic              rec_clear_n,
  output logic              record_n,
  output logic [ADDR_W-1:0] read_pointer,
  output logic [DATA_W-1:0] play_data,
  output logic              play_valid,
  output logic              dump_grant,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] rec_len,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2,
    ST_DUMP   = 2'd3
  } state_t;

  localparam int CNT_W = (SAMPLE_INTERVAL_CLK > 1) ? $clog2(SAMPLE_INTERVAL_CLK) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_INTERVAL_CLK - 1);
  localparam logic [ADDR_W-1:0] MEM_FULL = ADDR_W'(MEMORY_SIZE);

  state_t              state_q, state_d;
  logic                rec_clear_n_q, rec_clear_n_d;
  logic                record_n_q, record_n_d;
  logic [ADDR_W-1:0]   read_pointer_q, read_pointer_d;
  logic [DATA_W-1:0]   play_data_q, play_data_d;
  logic                play_valid_q, play_valid_d;
  logic                dump_grant_q, dump_grant_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic                dump_valid_q, dump_valid_d;
  logic [ADDR_W-1:0]   rec_len_q, rec_len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n_clk) begin
    if (!reset_n_clk) begin
      state_q        <= ST_IDLE;
      rec_clear_n_q  <= 1'b1;
      record_n_q     <= 1'b1;
      read_pointer_q <= '0;
      play_data_q    <= '0;
      play_valid_q   <= 1'b0;
      dump_grant_q   <= 1'b0;
      dump_data_q    <= '0;
      dump_valid_q   <= 1'b0;
      rec_len_q      <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      rec_clear_n_q  <= rec_clear_n_d;
      record_n_q     <= record_n_d;
      read_pointer_q <= read_pointer_d;
      play_data_q    <= play_data_d;
      play_valid_q   <= play_valid_d;
      dump_grant_q   <= dump_grant_d;
      dump_data_q    <= dump_data_d;
      dump_valid_q   <= dump_valid_d;
      rec_len_q      <= rec_len_d;
      cnt_q          <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rec_clear_n_d  = 1'b1;
    record_n_d     = record_n_q;
    read_pointer_d = read_pointer_q;
    play_data_d    = play_data_q;
    play_valid_d   = 1'b0;
    dump_grant_d   = dump_grant_q;
    dump_data_d    = dump_data_q;
    dump_valid_d   = dump_valid_q;
    rec_len_d      = rec_len_q;
    cnt_d          = cnt_q;

    case (state_q)
      ST_IDLE: begin
        read_pointer_d = '0;
        cnt_d          = '0;
        record_n_d     = 1'b1;
        dump_grant_d   = 1'b0;
        dump_valid_d   = 1'b0;
        // A stop pulse outranks every other request and simply keeps us idle.
        if (!stop_req) begin
          if (rec_req) begin
            state_d       = ST_RECORD;
            rec_clear_n_d = 1'b0;
          end else if (play_req && (rec_len_q != '0)) begin
            state_d = ST_PLAY;
          end else if (dump_req) begin
            state_d      = ST_DUMP;
            dump_grant_d = 1'b1;
          end
        end
      end

      ST_RECORD: begin
        if (stop_req || (write_pointer == MEM_FULL)) begin
          state_d    = ST_IDLE;
          record_n_d = 1'b1;
          rec_len_d  = write_pointer;
        end else begin
          record_n_d = 1'b0;
        end
      end

      ST_PLAY: begin
        if (stop_req) begin
          state_d        = ST_IDLE;
          read_pointer_d = '0;
          cnt_d          = '0;
        end else if (cnt_q == CNT_LAST) begin
          play_data_d  = read_data;
          play_valid_d = 1'b1;
          cnt_d        = '0;
          // Leave as soon as the last recorded sample goes out so the pointer never passes rec_len.
          if ((read_pointer_q + ADDR_W'(1)) == rec_len_q) begin
            state_d        = ST_IDLE;
            read_pointer_d = '0;
          end else begin
            read_pointer_d = read_pointer_q + ADDR_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DUMP: begin
        if (stop_req || !dump_req) begin
          state_d        = ST_IDLE;
          dump_grant_d   = 1'b0;
          dump_valid_d   = 1'b0;
          read_pointer_d = '0;
        end else begin
          read_pointer_d = dump_addr;
          dump_data_d    = read_data;
          dump_valid_d   = (read_pointer_q < rec_len_q);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rec_clear_n  = rec_clear_n_q;
  assign record_n     = record_n_q;
  assign read_pointer = read_pointer_q;
  assign play_data    = play_data_q;
  assign play_valid   = play_valid_q;
  assign dump_grant   = dump_grant_q;
  assign dump_data    = dump_data_q;
  assign dump_valid   = dump_valid_q;
  assign rec_len      = rec_len_q;
  assign state        = state_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer: vector table for record/dump flows, hand sequences for playback and reset.
module tb_sound_sequencer;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 10;

  logic              clk = 1'b0;
  logic              reset_n_clk = 1'b1;
  logic              rec_req = 1'b0, play_req = 1'b0, stop_req = 1'b0, dump_req = 1'b0;
  logic [ADDR_W-1:0] dump_addr = '0, write_pointer = '0;
  logic [DATA_W-1:0] read_data;
  logic              rec_clear_n, record_n, play_valid, dump_grant, dump_valid;
  logic [ADDR_W-1:0] read_pointer, rec_len;
  logic [DATA_W-1:0] play_data, dump_data;
  logic [1:0]        state;

  int n_vec = 0;
  int n_bad = 0;

  sound_sequencer #(
    .SAMPLE_INTERVAL_CLK(4),
    .MEMORY_SIZE        (16),
    .ADDR_W             (ADDR_W),
    .DATA_W             (DATA_W)
  ) dut (
    .clk          (clk),
    .reset_n_clk  (reset_n_clk),
    .rec_req      (rec_req),
    .play_req     (play_req),
    .stop_req     (stop_req),
    .dump_req     (dump_req),
    .dump_addr    (dump_addr),
    .write_pointer(write_pointer),
    .read_data    (read_data),
    .rec_clear_n  (rec_clear_n),
    .record_n     (record_n),
    .read_pointer (read_pointer),
    .play_data    (play_data),
    .play_valid   (play_valid),
    .dump_grant   (dump_grant),
    .dump_data    (dump_data),
    .dump_valid   (dump_valid),
    .rec_len      (rec_len),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Recorder memory model: memory[i] = i + 100.
  assign read_data = DATA_W'(read_pointer + ADDR_W'(100));

  typedef struct {
    logic              rec, play, stop, dump;
    logic [ADDR_W-1:0] daddr, wp;
    logic [1:0]        st;
    logic              rcn, rn;
    logic [ADDR_W-1:0] rp;
    logic              pv, dg, dv;
    logic [DATA_W-1:0] dd;
    logic [ADDR_W-1:0] rl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int rec, play, stop, dump, daddr, wp,
                              input int st, rcn, rn, rp, pv, dg, dv, dd, rl);
    vec_t v;
    v.rec = 1'(rec);   v.play = 1'(play); v.stop = 1'(stop); v.dump = 1'(dump);
    v.daddr = ADDR_W'(daddr); v.wp = ADDR_W'(wp);
    v.st = 2'(st);     v.rcn = 1'(rcn);   v.rn = 1'(rn);     v.rp = ADDR_W'(rp);
    v.pv = 1'(pv);     v.dg = 1'(dg);     v.dv = 1'(dv);
    v.dd = DATA_W'(dd); v.rl = ADDR_W'(rl);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    rec_req = v.rec; play_req = v.play; stop_req = v.stop; dump_req = v.dump;
    dump_addr = v.daddr; write_pointer = v.wp;
    step();
    n_vec++;
    if (state !== v.st || rec_clear_n !== v.rcn || record_n !== v.rn || read_pointer !== v.rp ||
        play_valid !== v.pv || dump_grant !== v.dg || dump_valid !== v.dv ||
        dump_data !== v.dd || rec_len !== v.rl) begin
      n_bad++;
      $display("FAIL vec%0d: got st=%0d rcn=%0d rn=%0d rp=%0d pv=%0d dg=%0d dv=%0d dd=%0d rl=%0d, expected st=%0d rcn=%0d rn=%0d rp=%0d pv=%0d dg=%0d dv=%0d dd=%0d rl=%0d",
               idx, state, rec_clear_n, record_n, read_pointer, play_valid, dump_grant, dump_valid,
               dump_data, rec_len, v.st, v.rcn, v.rn, v.rp, v.pv, v.dg, v.dv, v.dd, v.rl);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_rec_clear_n"}, int'(rec_clear_n), 1);
    chk({tag, "_record_n"}, int'(record_n), 1);
    chk({tag, "_read_pointer"}, int'(read_pointer), 0);
    chk({tag, "_play_data"}, int'(play_data), 0);
    chk({tag, "_play_valid"}, int'(play_valid), 0);
    chk({tag, "_dump_grant"}, int'(dump_grant), 0);
    chk({tag, "_dump_data"}, int'(dump_data), 0);
    chk({tag, "_dump_valid"}, int'(dump_valid), 0);
    chk({tag, "_rec_len"}, int'(rec_len), 0);
  endtask

  initial begin
    int hits;

    // Idle behaviour with nothing recorded
    vq.push_back(mk(0,0,0,0, 0,0,  0,1,1,0, 0,0,0,0,0));
    vq.push_back(mk(0,1,0,0, 0,0,  0,1,1,0, 0,0,0,0,0));
    vq.push_back(mk(0,0,1,0, 0,0,  0,1,1,0, 0,0,0,0,0));
    vq.push_back(mk(1,0,1,0, 0,0,  0,1,1,0, 0,0,0,0,0));
    // Record until memory full
    vq.push_back(mk(1,0,0,0, 0,0,  1,0,1,0, 0,0,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,  1,1,0,0, 0,0,0,0,0));
    for (int w = 1; w <= 15; w++)
      vq.push_back(mk(0,0,0,0, 0,w,  1,1,0,0, 0,0,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,16, 0,1,1,0, 0,0,0,0,16));
    // Record stopped at write_pointer=5
    vq.push_back(mk(1,0,0,0, 0,0,  1,0,1,0, 0,0,0,0,16));
    vq.push_back(mk(0,0,0,0, 0,0,  1,1,0,0, 0,0,0,0,16));
    for (int w = 1; w <= 4; w++)
      vq.push_back(mk(0,0,0,0, 0,w,  1,1,0,0, 0,0,0,0,16));
    vq.push_back(mk(0,0,1,0, 0,5,  0,1,1,0, 0,0,0,0,5));
    // Dump addresses 3 then 7, then release
    vq.push_back(mk(0,0,0,1, 3,5,  3,1,1,0, 0,1,0,0,5));
    vq.push_back(mk(0,0,0,1, 3,5,  3,1,1,3, 0,1,1,100,5));
    vq.push_back(mk(0,0,0,1, 7,5,  3,1,1,7, 0,1,1,103,5));
    vq.push_back(mk(0,0,0,1, 7,5,  3,1,1,7, 0,1,0,107,5));
    vq.push_back(mk(0,0,0,1, 7,5,  3,1,1,7, 0,1,0,107,5));
    vq.push_back(mk(0,0,0,0, 0,5,  0,1,1,0, 0,0,0,107,5));
    // rec and dump together: record wins; stop during the arm cycle keeps rec_len=5
    vq.push_back(mk(1,0,0,1, 0,0,  1,0,1,0, 0,0,0,107,5));
    vq.push_back(mk(0,0,1,0, 0,5,  0,1,1,0, 0,0,0,107,5));

    #2 reset_n_clk = 1'b0;
    #1 chk_reset_values("reset");
    #9 reset_n_clk = 1'b1;

    foreach (vq[i]) apply(i, vq[i]);
    rec_req = 0; play_req = 0; stop_req = 0; dump_req = 0; dump_addr = '0; write_pointer = 5;

    // Full playback of 5 samples, with a rec_req that must be ignored
    play_req = 1; step(); play_req = 0;
    chk("play_entry_state", int'(state), 2);
    hits = 0;
    for (int k = 1; k <= 30; k++) begin
      rec_req = (k == 2);
      step();
      rec_req = 0;
      if (k == 2) begin
        chk("rec_in_play_state", int'(state), 2);
        chk("rec_in_play_record_n", int'(record_n), 1);
      end
      if (play_valid) begin
        chk("play_strobe_cycle", k, 4 * (hits + 1));
        chk("play_data", int'(play_data), 100 + hits);
        hits++;
      end
      if (k == 20) begin
        chk("play_done_state", int'(state), 0);
        chk("play_done_rp", int'(read_pointer), 0);
      end
    end
    chk("play_strobe_count", hits, 5);
    chk("play_data_held", int'(play_data), 104);

    // Stop after the second sample
    play_req = 1; step(); play_req = 0;
    hits = 0;
    for (int k = 1; k <= 24; k++) begin
      stop_req = (k == 9);
      step();
      stop_req = 0;
      if (play_valid) hits++;
      if (k == 9) chk("stop_play_state", int'(state), 0);
    end
    chk("stop_play_count", hits, 2);
    chk("stop_play_data_held", int'(play_data), 101);

    // Reset in the middle of playback
    play_req = 1; step(); play_req = 0;
    repeat (6) step();
    chk("pre_reset_state", int'(state), 2);
    #2 reset_n_clk = 1'b0;
    #1 chk_reset_values("midplay_reset");
    #2 reset_n_clk = 1'b1;
    play_req = 1; step(); play_req = 0;
    chk("post_reset_play_ignored", int'(state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
